// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_N_BIT    = 96;
  localparam int unsigned DEF_N_FRAMES = 8;
  localparam int unsigned DEF_GAP      = 4;
  localparam int unsigned WCNT_W       = 16;
  localparam int unsigned PAR_W        = 1024;

  // Even parity over a zero-extended vector; callers cast narrower words up to PAR_W.
  function automatic logic even_parity(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/spi_cfg_regbank.sv
// Frame bank: N_FRAMES x N_BIT, synchronous write, asynchronous read, cleared by reset.
module spi_cfg_regbank
  import spi_cfg_pkg::*;
#(
  parameter int unsigned N_BIT    = DEF_N_BIT,
  parameter int unsigned N_FRAMES = DEF_N_FRAMES,
  parameter int unsigned AW       = $clog2(DEF_N_FRAMES)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [N_BIT-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [N_BIT-1:0] rdata
);

  logic [N_BIT-1:0] mem [N_FRAMES];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < N_FRAMES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Replays configuration frames to the SPI write master at a fixed frame pace.
// Optional SPI_CFG_PARITY_EN: outgoing MSB replaced by even parity of the lower bits.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter  int unsigned N_BIT    = DEF_N_BIT,
  parameter  int unsigned N_FRAMES = DEF_N_FRAMES,
  parameter  int unsigned GAP      = DEF_GAP,
  localparam int unsigned AW       = $clog2(N_FRAMES)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             pll_locked,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_BIT-1:0] cfg_wdata,
  input  logic [AW:0]      n_frames,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             cfg_err,
  output logic             wreq,
  output logic [N_BIT-1:0] wdata
);

  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(N_BIT + 2 + GAP - 1);
  localparam logic [AW:0]       NF_MAX    = (AW+1)'(N_FRAMES);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      nfr_q, nfr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic             busy_d, done_d, abort_d, cfg_err_d, wreq_d;
  logic [N_BIT-1:0] wdata_d, rd_word, frame_out;
  logic             n_ok, start_ok, addr_ok, bank_we, is_last;

  assign n_ok     = (n_frames != '0) && (n_frames <= NF_MAX);
  assign start_ok = (state_q == ST_IDLE) && start && pll_locked && n_ok;
  assign addr_ok  = ({1'b0, cfg_addr} < NF_MAX);
  assign bank_we  = cfg_we && (state_q == ST_IDLE) && addr_ok;
  assign is_last  = ({1'b0, idx_q} == (nfr_q - (AW+1)'(1)));

  // Read port follows the next index so wdata is registered on the edge entering REQ.
  spi_cfg_regbank #(
    .N_BIT   (N_BIT),
    .N_FRAMES(N_FRAMES),
    .AW      (AW)
  ) u_bank (
    .clk  (clk),
    .nrst (nrst),
    .we   (bank_we),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr(idx_d),
    .rdata(rd_word)
  );

`ifdef SPI_CFG_PARITY_EN
  assign frame_out = {even_parity(PAR_W'(rd_word[N_BIT-2:0])), rd_word[N_BIT-2:0]};
`else
  assign frame_out = rd_word;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      nfr_q   <= '0;
      wcnt_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      cfg_err <= 1'b0;
      wreq    <= 1'b0;
      wdata   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nfr_q   <= nfr_d;
      wcnt_q  <= wcnt_d;
      busy    <= busy_d;
      done    <= done_d;
      abort   <= abort_d;
      cfg_err <= cfg_err_d;
      wreq    <= wreq_d;
      wdata   <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (wcnt_q == '0) state_d = is_last ? ST_DONE : ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!pll_locked) state_d = ST_IDLE;
  end

  always_comb begin
    idx_d = idx_q;
    nfr_d = nfr_q;
    if (start_ok) begin
      idx_d = '0;
      nfr_d = n_frames;
    end else if ((state_q == ST_WAIT) && (wcnt_q == '0) && !is_last) begin
      idx_d = idx_q + AW'(1);
    end

    wcnt_d = wcnt_q;
    if (state_q == ST_REQ) begin
      wcnt_d = WCNT_LOAD;
    end else if ((state_q == ST_WAIT) && (wcnt_q != '0)) begin
      wcnt_d = wcnt_q - WCNT_W'(1);
    end

    wreq_d  = (state_d == ST_REQ);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    abort_d = (state_q != ST_IDLE) && !pll_locked;
    wdata_d = wreq_d ? frame_out : wdata;

    // Error sources take priority over the clear from a same-cycle accepted start.
    cfg_err_d = cfg_err;
    if (start_ok) cfg_err_d = 1'b0;
    if ((cfg_we && ((state_q != ST_IDLE) || !addr_ok)) ||
        ((state_q == ST_IDLE) && start && pll_locked && !n_ok))
      cfg_err_d = 1'b1;
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer; honours SPI_CFG_PARITY_EN when defined.
module tb_spi_cfg_sequencer;

  localparam int unsigned N_BIT    = 96;
  localparam int unsigned N_FRAMES = 8;
  localparam int unsigned GAP      = 4;
  localparam int unsigned AW       = 3;
  localparam int unsigned PERIOD   = N_BIT + 3 + GAP;

  logic             clk = 1'b0;
  logic             nrst, pll_locked, cfg_we, start;
  logic [AW-1:0]    cfg_addr;
  logic [N_BIT-1:0] cfg_wdata, wdata;
  logic [AW:0]      n_frames;
  logic             busy, done, abort, cfg_err, wreq;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(.N_BIT(N_BIT), .N_FRAMES(N_FRAMES), .GAP(GAP)) dut (
    .clk(clk), .nrst(nrst), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .n_frames(n_frames),
    .start(start), .busy(busy), .done(done), .abort(abort),
    .cfg_err(cfg_err), .wreq(wreq), .wdata(wdata)
  );

  typedef struct {
    logic [N_BIT-1:0] data;
    int unsigned      at;
  } exp_t;

  exp_t             exp_q[$];
  logic [N_BIT-1:0] bank_m [N_FRAMES];
  logic [N_BIT-1:0] last_wd;
  int unsigned      cyc = 0;
  int unsigned      n_vec = 0, n_bad = 0;
  int unsigned      done_cnt = 0, abort_cnt = 0, done_at = 0;
  logic             done_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [N_BIT-1:0] act, input logic [N_BIT-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [N_BIT-1:0] exp_word(input int unsigned i);
    logic [N_BIT-1:0] d;
    d = bank_m[i];
`ifdef SPI_CFG_PARITY_EN
    d[N_BIT-1] = ^d[N_BIT-2:0];
`endif
    return d;
  endfunction

  always @(negedge clk) begin
    if (nrst) begin
      if (done) begin
        done_cnt++;
        done_at   = cyc;
        done_busy = busy;
      end
      if (abort) abort_cnt++;
      if (wreq) begin
        if (exp_q.size() == 0) begin
          chk("wreq_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wdata", wdata, e.data);
          chk("wreq_cycle", cyc, e.at);
        end
      end else if (busy) begin
        chk("wdata_hold", wdata, last_wd);
      end
      last_wd = wdata;
    end
  end

  task automatic wr(input int unsigned a, input logic [N_BIT-1:0] d, input bit model);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (model) bank_m[a] = d;
  endtask

  task automatic start_seq(input int unsigned n, input bit accept, input bit with_wr,
                           input int unsigned wa, input logic [N_BIT-1:0] wd,
                           output int unsigned s);
    @(negedge clk);
    start = 1'b1; n_frames = (AW+1)'(n); s = cyc;
    if (with_wr) begin
      cfg_we = 1'b1; cfg_addr = AW'(wa); cfg_wdata = wd;
    end
    // Frame 0 is read on the start edge, so a same-cycle write only reaches later frames.
    if (accept) begin
      exp_t e;
      e.data = exp_word(0); e.at = s + 1;
      exp_q.push_back(e);
      if (with_wr) bank_m[wa] = wd;
      for (int unsigned k = 1; k < n; k++) begin
        e.data = exp_word(k); e.at = s + 1 + PERIOD * k;
        exp_q.push_back(e);
      end
    end else if (with_wr) begin
      bank_m[wa] = wd;
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    #1;
    if (accept) begin
      chk("busy_after_start", busy, 1);
      chk("cfg_err_cleared", cfg_err, 0);
    end
  endtask

  task automatic wait_done(input int unsigned s, input int unsigned n);
    int unsigned d0;
    d0 = done_cnt;
    for (int unsigned i = 0; i < PERIOD * n + 20 && done_cnt == d0; i++) @(posedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("done_cycle", done_at, s + 1 + PERIOD * n);
    chk("busy_during_done", done_busy, 1);
    @(negedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("frames_left", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned s, a0, d0;
    nrst = 1'b0; pll_locked = 1'b1; cfg_we = 1'b0; start = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; n_frames = '0;
    for (int unsigned i = 0; i < N_FRAMES; i++) bank_m[i] = '0;
    #23;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_abort", abort, 0); chk("rst_cfg_err", cfg_err, 0);
    chk("rst_wreq", wreq, 0);   chk("rst_wdata", wdata, 0);
    @(negedge clk); nrst = 1'b1;

    // Three-frame sequence
    wr(0, {12{8'hA5}}, 1);
    wr(1, {12{8'h5A}}, 1);
    wr(2, {N_BIT{1'b1}}, 1);
    start_seq(3, 1, 0, 0, '0, s);
    wait_done(s, 3);
    chk("cfg_err_clean", cfg_err, 0);

    // Bad n_frames values, then recovery
    start_seq(0, 0, 0, 0, '0, s);
    chk("cfg_err_nf0", cfg_err, 1);
    chk("busy_nf0", busy, 0);
    repeat (5) @(negedge clk);
    #1 chk("busy_nf0_later", busy, 0);
    start_seq(9, 0, 0, 0, '0, s);
    chk("cfg_err_nf9", cfg_err, 1);
    start_seq(1, 1, 0, 0, '0, s);
    wait_done(s, 1);

    // Writes and starts while busy are dropped
    start_seq(2, 1, 0, 0, '0, s);
    repeat (30) @(negedge clk);
    wr(0, 96'h1234, 0);
    #1 chk("cfg_err_busy_we", cfg_err, 1);
    @(negedge clk);
    start = 1'b1; n_frames = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(s, 2);
    chk("cfg_err_sticky", cfg_err, 1);
    start_seq(1, 1, 0, 0, '0, s);
    wait_done(s, 1);

    // Lock loss during frame 1 wait
    a0 = abort_cnt; d0 = done_cnt;
    start_seq(3, 1, 0, 0, '0, s);
    repeat (PERIOD + 20) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk); #1;
    chk("abort_pulse", abort, 1);
    chk("busy_abort", busy, 0);
    chk("wreq_abort", wreq, 0);
    chk("pending_at_abort", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk); #1 chk("abort_one_cycle", abort, 0);
    start_seq(1, 0, 0, 0, '0, s);
    repeat (3 * PERIOD) @(negedge clk);
    #1;
    chk("abort_count", abort_cnt - a0, 1);
    chk("no_done_abort", done_cnt - d0, 0);
    chk("busy_unlocked", busy, 0);
    pll_locked = 1'b1;
    start_seq(1, 1, 0, 0, '0, s);
    wait_done(s, 1);

    // MSB handling: odd and even populations below the MSB
    wr(3, 96'h1F, 1);
    wr(4, {1'b1, 95'h3}, 1);
    start_seq(5, 1, 0, 0, '0, s);
    wait_done(s, 5);

    // Write in the start cycle lands in a later frame
    start_seq(2, 1, 1, 1, {6{16'hCAFE}}, s);
    wait_done(s, 2);

    // Asynchronous reset mid-wait
    start_seq(2, 1, 0, 0, '0, s);
    repeat (40) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("amid_busy", busy, 0);   chk("amid_wreq", wreq, 0);
    chk("amid_wdata", wdata, 0); chk("amid_cfg_err", cfg_err, 0);
    chk("amid_done", done, 0);   chk("amid_abort", abort, 0);
    exp_q.delete();
    for (int unsigned i = 0; i < N_FRAMES; i++) bank_m[i] = '0;
    @(negedge clk); nrst = 1'b1;
    start_seq(2, 1, 0, 0, '0, s);
    wait_done(s, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
